// File: rtl/ds1302_pkg.sv
// Shared types and constants for the DS1302 3-wire serial engine.
package ds1302_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    DATA,
    HOLD,
    RECOVER
  } state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int RD_BIT        = 0;

  // Width of the phase counter: it must hold (largest timing parameter - 1).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/ds1302_serial_if.sv
// Request/response bus between the clock controller (master) and the serial engine (slave).
interface ds1302_serial_if;
  logic [7:0] addr;
  logic [7:0] w;
  logic       ena;
  logic [7:0] r;
  logic       done;

  modport master (output addr, output w, output ena, input r, input done);
  modport slave  (input addr, input w, input ena, output r, output done);
endinterface

// File: rtl/ds1302_timer.sv
// Loadable down-counter with a zero flag; times every phase and SCLK half-period.
module ds1302_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ds1302_serial.sv
// DS1302 single-byte 3-wire transfer engine (CE/SCLK/IO), registered pin outputs.
// Optional macro DS1302_IN_SYNC_EN: io_in passes through a 2-flop synchronizer.
module ds1302_serial
  import ds1302_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int CE_SETUP   = 200,
  parameter int CE_HOLD    = 50,
  parameter int CE_RECOVER = 200
) (
  input  logic             clk,
  input  logic             clr,
  ds1302_serial_if.slave   bus,
  output logic             rtc_ce,
  output logic             rtc_sclk,
  output logic             io_out,
  output logic             io_oe,
  input  logic             io_in
);

  localparam int CW = cnt_width(CLK_DIV, CE_SETUP, CE_HOLD, CE_RECOVER);
  localparam logic [CW-1:0] HALF_LD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(CE_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CE_HOLD - 1);
  localparam logic [CW-1:0] REC_LD   = CW'(CE_RECOVER - 1);
  localparam logic [2:0]    LAST_BIT = 3'(BITS_PER_BYTE - 1);

  state_t        state, state_n;
  logic [2:0]    bit_idx, bit_n, bit_inc;
  logic          rd;
  logic          ce_n, sclk_n, out_n, oe_n, done_n;
  logic          done_pulse;
  logic [7:0]    r_data;
  logic [7:0]    addr_l, w_l, shift;
  logic          load, zero, capture, sample, update_r;
  logic [CW-1:0] load_val;
  logic          io_s;

`ifdef DS1302_IN_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk) begin
    sync <= {sync[0], io_in};
  end
  assign io_s = sync[1];
`else
  assign io_s = io_in;
`endif

  ds1302_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst   (clr),
    .load  (load),
    .value (load_val),
    .zero  (zero)
  );

  assign bit_inc = bit_idx + 3'd1;

  always_comb begin
    state_n  = state;
    bit_n    = bit_idx;
    ce_n     = rtc_ce;
    sclk_n   = rtc_sclk;
    out_n    = io_out;
    oe_n     = io_oe;
    done_n   = 1'b0;
    load     = 1'b0;
    load_val = HALF_LD;
    capture  = 1'b0;
    sample   = 1'b0;
    update_r = 1'b0;

    case (state)
      IDLE: begin
        ce_n   = 1'b0;
        sclk_n = 1'b0;
        oe_n   = 1'b0;
        out_n  = 1'b0;
        if (bus.ena) begin
          capture  = 1'b1;
          state_n  = SETUP;
          ce_n     = 1'b1;
          out_n    = bus.addr[0];
          oe_n     = 1'b1;
          load     = 1'b1;
          load_val = SETUP_LD;
        end
      end
      SETUP: begin
        if (zero) begin
          state_n = CMD;
          bit_n   = 3'd0;
          load    = 1'b1;
        end
      end
      CMD, DATA: begin
        if (zero) begin
          load = 1'b1;
          if (!rtc_sclk) begin
            // End of low half: raise SCLK; read data is captured in this cycle.
            sclk_n = 1'b1;
            if (state == DATA && rd) sample = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (bit_idx == LAST_BIT) begin
              bit_n = 3'd0;
              if (state == CMD) begin
                state_n = DATA;
                out_n   = rd ? 1'b0 : w_l[0];
                oe_n    = ~rd;
              end else begin
                state_n  = HOLD;
                out_n    = 1'b0;
                oe_n     = 1'b0;
                load_val = HOLD_LD;
              end
            end else begin
              bit_n = bit_inc;
              if (state == CMD) out_n = addr_l[bit_inc];
              else              out_n = rd ? 1'b0 : w_l[bit_inc];
            end
          end
        end
      end
      HOLD: begin
        if (zero) begin
          state_n  = RECOVER;
          ce_n     = 1'b0;
          done_n   = 1'b1;
          update_r = rd;
          load     = 1'b1;
          load_val = REC_LD;
        end
      end
      RECOVER: begin
        if (zero) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      bit_idx    <= 3'd0;
      rd         <= 1'b0;
      rtc_ce     <= 1'b0;
      rtc_sclk   <= 1'b0;
      io_out     <= 1'b0;
      io_oe      <= 1'b0;
      done_pulse <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_n;
      rtc_ce     <= ce_n;
      rtc_sclk   <= sclk_n;
      io_out     <= out_n;
      io_oe      <= oe_n;
      done_pulse <= done_n;
      if (capture)  rd     <= bus.addr[RD_BIT];
      if (update_r) r_data <= shift;
    end
  end

  // Latched transfer operands and read shift register carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_l <= bus.addr;
      w_l    <= bus.w;
    end
    if (sample) shift[bit_idx] <= io_s;
  end

  assign bus.r    = r_data;
  assign bus.done = done_pulse;

endmodule

// File: tb/tb_ds1302_serial.sv
// Scoreboard bench for ds1302_serial with a behavioural DS1302 slave on the 3-wire bus.
module tb_ds1302_serial;

  localparam int CLK_DIV    = 4;
  localparam int CE_SETUP   = 200;
  localparam int CE_HOLD    = 50;
  localparam int CE_RECOVER = 200;
  localparam int N          = CE_SETUP + 32 * CLK_DIV + CE_HOLD;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic rtc_ce, rtc_sclk, io_out, io_oe, io_in;

  ds1302_serial_if bus ();

  always #5 clk = ~clk;

  ds1302_serial #(
    .CLK_DIV    (CLK_DIV),
    .CE_SETUP   (CE_SETUP),
    .CE_HOLD    (CE_HOLD),
    .CE_RECOVER (CE_RECOVER)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .bus      (bus),
    .rtc_ce   (rtc_ce),
    .rtc_sclk (rtc_sclk),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .io_in    (io_in)
  );

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] wdata;
    logic [7:0] r;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  logic [7:0] model_r = 8'h00;

  // Slave model state
  logic       slave_en = 1'b0;
  logic       slave_bit = 1'b1;
  logic [7:0] s_cmd = 8'h00;
  logic [7:0] s_wdata = 8'h00;
  logic [7:0] s_rdata;
  int         s_rises = 0;
  bit         s_contention = 0;
  bit         s_oe_bad = 0;
  logic       s_prev_ce = 1'b0;
  logic       s_prev_sclk = 1'b0;
  logic       line;

  assign io_in = io_oe ? io_out : (slave_en ? slave_bit : 1'b1);

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] slave_data(input logic [7:0] cmd);
    case (cmd)
      8'h81:   return 8'h80;
      8'h83:   return 8'h59;
      8'h85:   return 8'h23;
      8'h87:   return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  // Behavioural DS1302: samples IO on SCLK rise, drives read bits after SCLK fall.
  always @(negedge clk) begin
    if (!rtc_ce) begin
      slave_en = 1'b0;
    end else begin
      if (!s_prev_ce) begin
        s_rises = 0; s_cmd = 8'h00; s_wdata = 8'h00;
        s_contention = 0; s_oe_bad = 0; slave_en = 1'b0;
      end
      if (io_oe && slave_en) s_contention = 1;
      if (rtc_sclk && !s_prev_sclk) begin
        line = io_oe ? io_out : (slave_en ? slave_bit : 1'b1);
        if ((s_rises < 8 || !s_cmd[0]) && !io_oe) s_oe_bad = 1;
        if (s_rises < 8) s_cmd[s_rises[2:0]] = line;
        else if (s_rises < 16 && !s_cmd[0]) s_wdata[s_rises[2:0]] = line;
        s_rises++;
      end
      if (!rtc_sclk && s_prev_sclk) begin
        if (s_cmd[0] && s_rises >= 8 && s_rises < 16) begin
          s_rdata   = slave_data(s_cmd);
          slave_en  = 1'b1;
          slave_bit = s_rdata[s_rises[2:0]];
        end else begin
          slave_en = 1'b0;
        end
      end
    end
    s_prev_ce   = rtc_ce;
    s_prev_sclk = rtc_sclk;
  end

  // Monitor: timing checks on the pins and scoreboard pop on every done.
  int   cyc = 0, t_ce = 0, t_fall_ce = 0, t_sclk_fall = 0;
  bit   have_fall = 0, first_rise_pending = 0;
  logic m_prev_ce = 1'b0, m_prev_sclk = 1'b0, m_prev_done = 1'b0, m_prev_oe = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (clr) begin
      have_fall = 0;
      first_rise_pending = 0;
      m_prev_done = 1'b0;
    end else begin
      if (rtc_ce && !m_prev_ce) begin
        t_ce = cyc;
        first_rise_pending = 1;
        if (have_fall) check("ce_recover_gap", int'(cyc - t_fall_ce >= CE_RECOVER), 1);
      end
      if (rtc_sclk && !m_prev_sclk && first_rise_pending) begin
        first_rise_pending = 0;
        check("ce_setup", int'(cyc - t_ce >= CE_SETUP), 1);
      end
      if (!rtc_sclk && m_prev_sclk) begin
        t_sclk_fall = cyc;
        if (s_rises == 8) check("oe_after_cmd", int'({m_prev_oe, io_oe}), int'({1'b1, ~s_cmd[0]}));
      end
      if (!rtc_ce && m_prev_ce) begin
        t_fall_ce = cyc;
        have_fall = 1;
        check("ce_hold", int'(cyc - t_sclk_fall >= CE_HOLD), 1);
      end
      if (m_prev_done) check("done_width", int'(bus.done), 0);
      if (bus.done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no transfer pending");
        end else begin
          e = exp_q.pop_front();
          check("r", int'(bus.r), int'(e.r));
          check("latency", cyc - t_ce, N);
          check("slave_cmd", int'(s_cmd), int'(e.cmd));
          check("sclk_rises", s_rises, 16);
          if (!e.cmd[0]) check("slave_wdata", int'(s_wdata), int'(e.wdata));
          check("oe_during_drive", int'(s_oe_bad), 0);
          check("io_contention", int'(s_contention), 0);
        end
      end
      m_prev_done = bus.done;
    end
    m_prev_ce   = rtc_ce;
    m_prev_sclk = rtc_sclk;
    m_prev_oe   = io_oe;
  end

  task automatic issue(input logic [7:0] cmd, input logic [7:0] wdata, input bit push);
    exp_t x;
    @(negedge clk);
    if (push) begin
      if (cmd[0]) model_r = slave_data(cmd);
      x.cmd = cmd; x.wdata = wdata; x.r = model_r;
      exp_q.push_back(x);
    end
    bus.addr = cmd;
    bus.w    = wdata;
    bus.ena  = 1'b1;
    @(negedge clk);
    bus.ena  = 1'b0;
    bus.addr = ~cmd;
    bus.w    = ~wdata;
  endtask

  task automatic push_read(input logic [7:0] cmd);
    exp_t x;
    model_r = slave_data(cmd);
    x.cmd = cmd; x.wdata = 8'h00; x.r = model_r;
    exp_q.push_back(x);
  endtask

  task automatic wait_done(input string name, input int maxc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < maxc);
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL %s: got no done within %0d cycles expected done", name, maxc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved_done;
    bit bad;
    bus.addr = 8'h00;
    bus.w    = 8'h00;
    bus.ena  = 1'b0;
    #2 clr = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ce", int'(rtc_ce), 0);
    check("rst_sclk", int'(rtc_sclk), 0);
    check("rst_io_out", int'(io_out), 0);
    check("rst_io_oe", int'(io_oe), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_r", int'(bus.r), 0);
    clr = 1'b0;
    repeat (2) @(negedge clk);

    // Write 8E/00
    issue(8'h8E, 8'h00, 1);
    wait_done("write_8e", N + 20);
    repeat (CE_RECOVER + 5) @(negedge clk);

    // Single read
    issue(8'h81, 8'h00, 1);
    wait_done("read_81", N + 20);
    repeat (CE_RECOVER + 5) @(negedge clk);

    // Back-to-back reads with ena held high
    push_read(8'h81);
    bus.addr = 8'h81;
    bus.ena  = 1'b1;
    wait_done("b2b_81", N + 20);
    bus.addr = 8'h83;
    push_read(8'h83);
    wait_done("b2b_83", N + CE_RECOVER + 20);
    bus.addr = 8'h85;
    push_read(8'h85);
    wait_done("b2b_85", N + CE_RECOVER + 20);
    bus.ena = 1'b0;
    repeat (CE_RECOVER + 5) @(negedge clk);

    // Reset in the middle of the DATA phase
    saved_done = done_count;
    issue(8'h83, 8'h00, 0);
    repeat (CE_SETUP + 16 * CLK_DIV + 6) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("abort_ce", int'(rtc_ce), 0);
    check("abort_sclk", int'(rtc_sclk), 0);
    check("abort_oe", int'(io_oe), 0);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    repeat (CE_RECOVER + 10) @(negedge clk);
    check("abort_no_done", done_count, saved_done);
    issue(8'h85, 8'h00, 1);
    wait_done("read_after_abort", N + 20);
    repeat (CE_RECOVER + 5) @(negedge clk);

    // Idle with ena low
    bad = 0;
    saved_done = done_count;
    repeat (1000) begin
      @(negedge clk);
      if (rtc_ce || rtc_sclk || bus.done) bad = 1;
    end
    check("idle_quiet", int'(bad), 0);
    check("idle_no_done", done_count, saved_done);

    // Read A5 (exercises the synchronizer when DS1302_IN_SYNC_EN is defined)
    issue(8'h87, 8'h00, 1);
    wait_done("read_87", N + 20);
    repeat (CE_RECOVER + 5) @(negedge clk);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
